// File: rtl/out_port_pkg.sv
// rtl/out_port_pkg.sv - shared constants and helpers for the output-port controller
package out_port_pkg;

  localparam logic MODE_LATCH = 1'b0;
  localparam logic MODE_FIFO  = 1'b1;

  // A select of one item still needs a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/out_port_chan.sv
// rtl/out_port_chan.sv - one output channel: latched register or FIFO with valid/ready drain
module out_port_chan
  import out_port_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              o_ready,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              wr_full,
  output logic              ovf
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] hold_reg;
  logic              mode_q;
  logic              lat_pulse;

  logic flush, is_fifo, full, empty, push, pop, drop, lat_wr;

  // A mode edge turns the next edge into a flush; nothing else happens then.
  assign flush   = (mode != mode_q);
  assign is_fifo = (mode_q == MODE_FIFO);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = is_fifo && wr_en && !flush && !full;
  assign drop    = is_fifo && wr_en && !flush && full;
  assign pop     = is_fifo && !empty && o_ready && !flush;
  assign lat_wr  = (mode_q == MODE_LATCH) && wr_en && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hold_reg  <= '0;
      mode_q    <= mode;
      lat_pulse <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      mode_q    <= mode;
      lat_pulse <= lat_wr;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) begin
          rd_ptr   <= rd_ptr + PW'(1);
          hold_reg <= mem[rd_ptr];
        end else if (lat_wr) begin
          hold_reg <= wr_data;
        end
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign o_valid = is_fifo ? !empty : lat_pulse;
  assign o_data  = (is_fifo && !empty) ? mem[rd_ptr] : hold_reg;
  assign wr_full = full;

endmodule

// File: rtl/out_port_fifo.sv
// rtl/out_port_fifo.sv - multi-channel CPU output port with per-channel latched/FIFO mode
module out_port_fifo
  import out_port_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NUM_CH = 2,
  parameter  int DEPTH  = 4,
  localparam int CH_W   = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [NUM_CH-1:0]        wr_full,
  input  logic [NUM_CH-1:0]        mode,
  output logic [NUM_CH*DATA_W-1:0] o_data,
  output logic [NUM_CH-1:0]        o_valid,
  input  logic [NUM_CH-1:0]        o_ready,
  output logic [NUM_CH-1:0]        ovf,
  input  logic [NUM_CH-1:0]        ovf_clr
);

  // Out-of-range channel numbers match no instance and are silently ignored.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_en && (wr_ch == CH_W'(c));

    out_port_chan #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .mode    (mode[c]),
      .wr_en   (ch_wr),
      .wr_data (wr_data),
      .o_ready (o_ready[c]),
      .ovf_clr (ovf_clr[c]),
      .o_data  (o_data[c*DATA_W +: DATA_W]),
      .o_valid (o_valid[c]),
      .wr_full (wr_full[c]),
      .ovf     (ovf[c])
    );
  end

endmodule

// File: tb/tb_out_port_fifo.sv
// tb/tb_out_port_fifo.sv - self-checking bench for out_port_fifo
module tb_out_port_fifo;

  localparam int NCH   = 3;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wr_en = 1'b0;
  logic [1:0]      wr_ch = '0;
  logic [7:0]      wr_data = '0;
  logic [NCH-1:0]  wr_full;
  logic [NCH-1:0]  mode = '0;
  logic [NCH*8-1:0] o_data;
  logic [NCH-1:0]  o_valid;
  logic [NCH-1:0]  o_ready = '0;
  logic [NCH-1:0]  ovf;
  logic [NCH-1:0]  ovf_clr = '0;

  int n_vec = 0;
  int n_err = 0;

  out_port_fifo #(.DATA_W(8), .NUM_CH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .wr_full(wr_full), .mode(mode), .o_data(o_data), .o_valid(o_valid),
    .o_ready(o_ready), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue per channel plus the visible last value.
  logic [7:0] mq [NCH][$];
  logic [7:0] m_hold  [NCH];
  logic       m_pulse [NCH];
  logic       m_ovf   [NCH];
  logic       m_mode  [NCH];

  function automatic logic exp_valid(int c);
    return m_mode[c] ? (mq[c].size() != 0) : m_pulse[c];
  endfunction

  function automatic logic [7:0] exp_data(int c);
    return (m_mode[c] && mq[c].size() != 0) ? mq[c][0] : m_hold[c];
  endfunction

  function automatic logic exp_full(int c);
    return mq[c].size() == DEPTH;
  endfunction

  task automatic model_update();
    bit wr, flush, full_b, popv;
    for (int c = 0; c < NCH; c++) begin
      wr = wr_en && (int'(wr_ch) == c);
      if (rst) begin
        mq[c].delete();
        m_hold[c] = 8'h00; m_pulse[c] = 1'b0; m_ovf[c] = 1'b0; m_mode[c] = mode[c];
      end else begin
        flush  = (mode[c] != m_mode[c]);
        full_b = (mq[c].size() == DEPTH);
        popv   = m_mode[c] && mq[c].size() != 0 && o_ready[c] && !flush;
        m_pulse[c] = 1'b0;
        if (flush) mq[c].delete();
        else if (m_mode[c]) begin
          if (popv) m_hold[c] = mq[c].pop_front();
          if (wr && !full_b) mq[c].push_back(wr_data);
        end else if (wr) begin
          m_hold[c] = wr_data; m_pulse[c] = 1'b1;
        end
        if (wr && !flush && m_mode[c] && full_b) m_ovf[c] = 1'b1;
        else if (ovf_clr[c]) m_ovf[c] = 1'b0;
        m_mode[c] = mode[c];
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write(input int ch, input logic [7:0] d);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    mode = '0; rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (o_data !== '0 || o_valid !== '0 || ovf !== '0 || wr_full !== '0) begin
      n_err++;
      $display("FAIL reset: data %h valid %b ovf %b full %b, want all 0", o_data, o_valid, ovf, wr_full);
    end
  endtask

  task automatic test_latched();
    write(0, 8'h55);
    n_vec++;
    if (o_data[7:0] !== 8'h55 || o_valid[0] !== 1'b1) begin
      n_err++; $display("FAIL latched_load: data %h valid %b, want 55 1", o_data[7:0], o_valid[0]);
    end
    step();
    n_vec++;
    if (o_valid[0] !== 1'b0) begin
      n_err++; $display("FAIL latched_pulse: valid %b, want 0", o_valid[0]);
    end
    repeat (10) step();
    n_vec++;
    if (o_data[7:0] !== 8'h55 || o_valid !== '0 || wr_full !== '0) begin
      n_err++; $display("FAIL latched_hold: data %h valid %b full %b, want 55 000 000", o_data[7:0], o_valid, wr_full);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    mode[1] = 1'b1; o_ready[1] = 1'b0;
    step();
    for (int i = 0; i < 4; i++) write(1, vals[i]);
    n_vec++;
    if (wr_full[1] !== 1'b1 || o_valid[1] !== 1'b1 || o_data[15:8] !== 8'h11) begin
      n_err++; $display("FAIL fifo_fill: full %b valid %b data %h, want 1 1 11", wr_full[1], o_valid[1], o_data[15:8]);
    end
    write(1, 8'h99);
    n_vec++;
    if (ovf[1] !== 1'b1 || wr_full[1] !== 1'b1 || ovf[0] !== 1'b0) begin
      n_err++; $display("FAIL fifo_ovf: ovf %b full %b, want 01x 1", ovf, wr_full[1]);
    end
    o_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (o_data[15:8] !== vals[i] || o_valid[1] !== 1'b1) begin
        n_err++; $display("FAIL fifo_drain%0d: data %h valid %b, want %h 1", i, o_data[15:8], o_valid[1], vals[i]);
      end
      step();
    end
    n_vec++;
    if (o_valid[1] !== 1'b0 || o_data[15:8] !== 8'h44 || wr_full[1] !== 1'b0) begin
      n_err++; $display("FAIL fifo_empty: valid %b data %h full %b, want 0 44 0", o_valid[1], o_data[15:8], wr_full[1]);
    end
    o_ready[1] = 1'b0; ovf_clr[1] = 1'b1;
    step();
    ovf_clr[1] = 1'b0;
    n_vec++;
    if (ovf[1] !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear: ovf %b, want 0", ovf[1]);
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] exp [4] = '{8'hA2, 8'hA0, 8'hB1, 8'hB2};
    mode[0] = 1'b1; o_ready[0] = 1'b0;
    step();
    write(0, 8'hA1);
    write(0, 8'hA2);
    o_ready[0] = 1'b1;
    write(0, 8'hA0);
    o_ready[0] = 1'b0;
    n_vec++;
    if (o_data[7:0] !== 8'hA2 || o_valid[0] !== 1'b1 || wr_full[0] !== 1'b0) begin
      n_err++; $display("FAIL push_pop: data %h valid %b full %b, want a2 1 0", o_data[7:0], o_valid[0], wr_full[0]);
    end
    write(0, 8'hB1);
    write(0, 8'hB2);
    n_vec++;
    if (wr_full[0] !== 1'b1) begin
      n_err++; $display("FAIL push_pop_count: full %b, want 1", wr_full[0]);
    end
    o_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (o_data[7:0] !== exp[i] || o_valid[0] !== 1'b1) begin
        n_err++; $display("FAIL push_pop_order%0d: data %h valid %b, want %h 1", i, o_data[7:0], o_valid[0], exp[i]);
      end
      step();
    end
    for (int i = 0; i < 10; i++) begin
      write(0, 8'hC0 + 8'(i));
      n_vec++;
      if (o_data[7:0] !== 8'hC0 + 8'(i) || o_valid[0] !== 1'b1) begin
        n_err++; $display("FAIL wrap%0d: data %h valid %b, want %h 1", i, o_data[7:0], o_valid[0], 8'hC0 + 8'(i));
      end
    end
    step();
    o_ready[0] = 1'b0;
    n_vec++;
    if (o_valid[0] !== 1'b0 || o_data[7:0] !== 8'hC9) begin
      n_err++; $display("FAIL wrap_end: valid %b data %h, want 0 c9", o_valid[0], o_data[7:0]);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) write(0, 8'hD0 + 8'(i));
    o_ready[0] = 1'b1;
    write(0, 8'hEE);
    o_ready[0] = 1'b0;
    n_vec++;
    if (ovf[0] !== 1'b1 || wr_full[0] !== 1'b0 || o_data[7:0] !== 8'hD1) begin
      n_err++; $display("FAIL full_pushpop: ovf %b full %b data %h, want 1 0 d1", ovf[0], wr_full[0], o_data[7:0]);
    end
    write(0, 8'hEF);
    ovf_clr[0] = 1'b1;
    write(0, 8'hF0);
    n_vec++;
    if (ovf[0] !== 1'b1 || wr_full[0] !== 1'b1) begin
      n_err++; $display("FAIL ovf_set_wins: ovf %b full %b, want 1 1", ovf[0], wr_full[0]);
    end
    step();
    ovf_clr[0] = 1'b0;
    n_vec++;
    if (ovf[0] !== 1'b0) begin
      n_err++; $display("FAIL ovf_clr0: ovf %b, want 0", ovf[0]);
    end
  endtask

  task automatic test_mode_flip();
    o_ready[0] = 1'b1;
    step();
    o_ready[0] = 1'b0;
    mode[0] = 1'b0;
    step();
    n_vec++;
    if (o_valid[0] !== 1'b0 || wr_full[0] !== 1'b0 || o_data[7:0] !== 8'hD1) begin
      n_err++; $display("FAIL mode_flush: valid %b full %b data %h, want 0 0 d1", o_valid[0], wr_full[0], o_data[7:0]);
    end
    write(0, 8'h3C);
    n_vec++;
    if (o_valid[0] !== 1'b1 || o_data[7:0] !== 8'h3C) begin
      n_err++; $display("FAIL mode_latched: valid %b data %h, want 1 3c", o_valid[0], o_data[7:0]);
    end
    write(3, 8'hFF);
    n_vec++;
    if (o_data !== 24'h00443C || o_valid !== 3'b000 || wr_full !== '0 || ovf !== '0) begin
      n_err++; $display("FAIL bad_channel: data %h valid %b full %b ovf %b, want 00443c 000 000 000", o_data, o_valid, wr_full, ovf);
    end
  endtask

  task automatic test_reset_mid();
    mode = 3'b110;
    step();
    write(1, 8'h71);
    write(2, 8'h72);
    write(1, 8'h73);
    n_vec++;
    if (o_valid !== 3'b110) begin
      n_err++; $display("FAIL mid_queue: valid %b, want 110", o_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (o_data !== '0 || o_valid !== '0 || wr_full !== '0 || ovf !== '0) begin
      n_err++; $display("FAIL mid_reset: data %h valid %b full %b ovf %b, want 0", o_data, o_valid, wr_full, ovf);
    end
    write(2, 8'h5A);
    n_vec++;
    if (o_valid !== 3'b100 || o_data[23:16] !== 8'h5A) begin
      n_err++; $display("FAIL post_reset: valid %b data %h, want 100 5a", o_valid, o_data[23:16]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      wr_en   = ($urandom_range(0, 9) < 7);
      wr_ch   = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom);
      o_ready = NCH'($urandom);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 39) == 0) mode[c] = ~mode[c];
        ovf_clr[c] = ($urandom_range(0, 7) == 0);
      end
      step();
      for (int c = 0; c < NCH; c++) begin
        n_vec++;
        if (o_valid[c] !== exp_valid(c) || o_data[c*8 +: 8] !== exp_data(c) ||
            wr_full[c] !== exp_full(c) || ovf[c] !== m_ovf[c]) begin
          n_err++;
          $display("FAIL random cyc%0d ch%0d: valid %b data %h full %b ovf %b, want %b %h %b %b",
                   n, c, o_valid[c], o_data[c*8 +: 8], wr_full[c], ovf[c],
                   exp_valid(c), exp_data(c), exp_full(c), m_ovf[c]);
        end
      end
    end
    rst = 1'b0; wr_en = 1'b0; ovf_clr = '0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latched();
    test_fifo_full();
    test_push_pop();
    test_full_push_pop();
    test_mode_flip();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
